// File: rtl/uart_core_pkg.sv
// Shared constants and state encodings for the Avalon-MM UART core.
// Register map, STATUS bit positions and TX/RX FSM state types.
package uart_core_pkg;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_RXDATA = 4'h2;

    localparam int unsigned STAT_TX_READY     = 0;
    localparam int unsigned STAT_RX_VALID     = 1;
    localparam int unsigned STAT_RX_OVERRUN   = 2;
    localparam int unsigned STAT_RX_FRAME_ERR = 3;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_core_avmm_if.sv
// Avalon-MM-style register port: 4-bit address, read/write strobes, 8-bit data.
interface uart_core_avmm_if;
    logic [3:0] avms_address_i;
    logic       avms_read_i;
    logic       avms_write_i;
    logic [7:0] avms_writedata_i;
    logic [7:0] avms_readdata_o;

    modport master (
        output avms_address_i, avms_read_i, avms_write_i, avms_writedata_i,
        input  avms_readdata_o
    );

    modport slave (
        input  avms_address_i, avms_read_i, avms_write_i, avms_writedata_i,
        output avms_readdata_o
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-flop synchroniser; samples at mid-bit, MSB first.
// Emits a one-cycle valid or frame-error pulse at the stop-bit sample.
module uart_rx
    import uart_core_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       rxd_i,
    output logic       valid_o,
    output logic       ferr_o,
    output logic [7:0] data_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntMax  = CW'(DIV - 1);
    localparam logic [CW-1:0] HalfCnt = CW'(DIV / 2);

    logic          s1_q, s2_q, prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          stop_sample;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (prev_q && !s2_q) state_d = RxStart;
            end
            RxStart: begin
                // Line back high at mid-start means it was a glitch.
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = s2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    shreg_d = {shreg_q[6:0], s2_q};
                    if (idx_q == 3'd7) state_d = RxStop;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            RxStop: begin
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RxIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            s1_q    <= rxd_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    assign stop_sample = (state_q == RxStop) && (cnt_q == CntMax);
    assign valid_o     = stop_sample && s2_q;
    assign ferr_o      = stop_sample && !s2_q;
    assign data_o      = shreg_q;
endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter, MSB first; each bit lasts DIV clocks, frame is 10*DIV clocks.
// A start request is only honoured while idle.
module uart_tx
    import uart_core_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        if (state_q == TxIdle) begin
            if (start_i) begin
                state_d = TxStart;
                cnt_d   = '0;
                idx_d   = '0;
                shreg_d = data_i;
                txd_d   = 1'b0;
            end
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
            unique case (state_q)
                TxStart: begin
                    state_d = TxData;
                    txd_d   = shreg_q[7];
                    shreg_d = {shreg_q[6:0], 1'b0};
                end
                TxData: begin
                    if (idx_q == 3'd7) begin
                        state_d = TxStop;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        txd_d   = shreg_q[7];
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
                TxStop:  state_d = TxIdle;
                default: state_d = TxIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    assign ready_o = (state_q == TxIdle);
    assign txd_o   = txd_q;
endmodule

// File: rtl/uart_core_avmm.sv
// 8N1 UART with Avalon-MM register port: register decode, read mux and RX flags.
// IRQ_event is a level interrupt that mirrors rx_valid.
module uart_core_avmm
    import uart_core_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic              clk_i,
    input  logic              arst_i,
    uart_core_avmm_if.slave   avms,
    output logic              uart_txd_o,
    input  logic              uart_rxd_i,
    output logic              IRQ_event
);
    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;

    logic       tx_start, tx_ready;
    logic       rx_done, rx_ferr;
    logic [7:0] rx_byte;
    logic       rd_rxdata;
    logic [7:0] status;

    logic [7:0] readdata_q, readdata_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       ferr_q, ferr_d;

    assign tx_start  = avms.avms_write_i && (avms.avms_address_i == ADDR_TXDATA);
    assign rd_rxdata = avms.avms_read_i && (avms.avms_address_i == ADDR_RXDATA);

    uart_tx #(.DIV(DIV)) u_tx (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .start_i (tx_start),
        .data_i  (avms.avms_writedata_i),
        .ready_o (tx_ready),
        .txd_o   (uart_txd_o)
    );

    uart_rx #(.DIV(DIV)) u_rx (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .rxd_i   (uart_rxd_i),
        .valid_o (rx_done),
        .ferr_o  (rx_ferr),
        .data_o  (rx_byte)
    );

    always_comb begin
        status                    = '0;
        status[STAT_TX_READY]     = tx_ready;
        status[STAT_RX_VALID]     = rx_valid_q;
        status[STAT_RX_OVERRUN]   = overrun_q;
        status[STAT_RX_FRAME_ERR] = ferr_q;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (avms.avms_read_i) begin
            unique case (avms.avms_address_i)
                ADDR_STATUS: readdata_d = status;
                ADDR_RXDATA: readdata_d = rx_data_q;
                default:     readdata_d = '0;
            endcase
        end
    end

    // A byte completing on the same edge as an RXDATA read wins over the clear;
    // it is not an overrun because the old byte was consumed by that read.
    always_comb begin
        rx_data_d  = rx_done ? rx_byte : rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        ferr_d     = ferr_q;
        if (rd_rxdata) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
            ferr_d     = 1'b0;
        end
        if (rx_done) begin
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_rxdata) overrun_d = 1'b1;
        end
        if (rx_ferr) ferr_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            readdata_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

    assign avms.avms_readdata_o = readdata_q;
    assign IRQ_event            = rx_valid_q;
endmodule

// File: tb/tb_uart_core_avmm.sv
// Directed self-checking bench for uart_core_avmm at DIV=16 (160 Hz / 10 baud).
module tb_uart_core_avmm;
    import uart_core_pkg::*;

    localparam int unsigned DIV = 16;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    logic rxd  = 1'b1;
    logic txd;
    logic irq;
    logic [7:0] rdat;
    int n_cmp = 0;
    int n_err = 0;

    uart_core_avmm_if bus ();

    uart_core_avmm #(.CLK_FREQ(160), .BAUD_RATE(10)) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .avms       (bus),
        .uart_txd_o (txd),
        .uart_rxd_i (rxd),
        .IRQ_event  (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.avms_address_i = a;
        bus.avms_read_i    = 1'b1;
        tick();
        bus.avms_read_i    = 1'b0;
        d = bus.avms_readdata_o;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.avms_address_i   = a;
        bus.avms_writedata_i = d;
        bus.avms_write_i     = 1'b1;
        tick();
        bus.avms_write_i     = 1'b0;
    endtask

    // Checks txd on every cycle of a frame; cycle 0 is the cycle right after the accepting edge.
    task automatic tx_frame(input logic [7:0] b, input bit busy, input int first);
        logic e;
        for (int c = first; c < int'(10 * DIV); c++) begin
            int k;
            k = c / int'(DIV);
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = b[8 - k];
            chk("txd_bit", {7'd0, txd}, {7'd0, e});
            if (busy && c == first) begin
                bus.avms_address_i   = ADDR_TXDATA;
                bus.avms_writedata_i = ~b;
                bus.avms_write_i     = 1'b1;
            end
            tick();
            bus.avms_write_i = 1'b0;
        end
    endtask

    task automatic poll_ready();
        logic [7:0] st;
        st = 8'h00;
        for (int i = 0; i < 50; i++) begin
            rd(ADDR_STATUS, st);
            if (st[0]) break;
        end
        chk("tx_ready_poll", {7'd0, st[0]}, 8'h01);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = fr[k];
            repeat (DIV) tick();
        end
        rxd = 1'b1;
    endtask

    logic [7:0] tx_bytes [12];

    initial begin
        tx_bytes = '{8'h48, 8'h45, 8'h4C, 8'h89, 8'h4F, 8'h5F,
                     8'h57, 8'h66, 8'h52, 8'h99, 8'h44, 8'h21};
        bus.avms_address_i   = 4'h0;
        bus.avms_read_i      = 1'b0;
        bus.avms_write_i     = 1'b0;
        bus.avms_writedata_i = 8'h00;

        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        chk("reset_readdata", bus.avms_readdata_o, 8'h00);
        chk("reset_txd", {7'd0, txd}, 8'h01);
        chk("reset_irq", {7'd0, irq}, 8'h00);
        rd(ADDR_STATUS, rdat);
        chk("reset_status", rdat, 8'h01);

        // Single 0x48 frame with status check just after acceptance
        poll_ready();
        wr(ADDR_TXDATA, 8'h48);
        chk("tx_start_low", {7'd0, txd}, 8'h00);
        rd(ADDR_STATUS, rdat);
        chk("status_busy", rdat, 8'h00);
        tx_frame(8'h48, 1'b0, 1);
        rd(ADDR_STATUS, rdat);
        chk("status_ready_after_frame", rdat, 8'h01);

        // Back-to-back frames, each with an ignored write while busy
        for (int i = 0; i < 12; i++) begin
            poll_ready();
            wr(ADDR_TXDATA, tx_bytes[i]);
            tx_frame(tx_bytes[i], 1'b1, 0);
        end

        // Unmapped addresses
        rd(4'h7, rdat);
        chk("unmapped_read", rdat, 8'h00);
        wr(4'h3, 8'h00);
        tick();
        tick();
        chk("unmapped_write_txd", {7'd0, txd}, 8'h01);
        rd(ADDR_STATUS, rdat);
        chk("unmapped_write_status", rdat, 8'h01);
        repeat (3) tick();
        chk("readdata_hold", bus.avms_readdata_o, 8'h01);

        // Single received byte
        rx_frame(8'h6E, 1'b1);
        chk("rx_irq_set", {7'd0, irq}, 8'h01);
        rd(ADDR_STATUS, rdat);
        chk("rx_status_valid", rdat, 8'h03);
        rd(ADDR_RXDATA, rdat);
        chk("rx_data_6e", rdat, 8'h6E);
        chk("rx_irq_cleared", {7'd0, irq}, 8'h00);
        rd(ADDR_STATUS, rdat);
        chk("rx_status_cleared", rdat, 8'h01);

        // Overrun
        rx_frame(8'hF8, 1'b1);
        rx_frame(8'h6E, 1'b1);
        rd(ADDR_STATUS, rdat);
        chk("overrun_status", rdat, 8'h07);
        rd(ADDR_RXDATA, rdat);
        chk("overrun_data", rdat, 8'h6E);
        rd(ADDR_STATUS, rdat);
        chk("overrun_cleared", rdat, 8'h01);

        // Framing error
        rx_frame(8'h55, 1'b0);
        repeat (DIV) tick();
        chk("ferr_irq", {7'd0, irq}, 8'h00);
        rd(ADDR_STATUS, rdat);
        chk("ferr_status", rdat, 8'h09);
        rd(ADDR_RXDATA, rdat);
        chk("ferr_data_kept", rdat, 8'h6E);
        rd(ADDR_STATUS, rdat);
        chk("ferr_cleared", rdat, 8'h01);

        // Short glitch rejected, then a clean byte still received
        rxd = 1'b0;
        repeat (5) tick();
        rxd = 1'b1;
        repeat (2 * DIV) tick();
        chk("glitch_irq", {7'd0, irq}, 8'h00);
        rd(ADDR_STATUS, rdat);
        chk("glitch_status", rdat, 8'h01);
        rx_frame(8'hA5, 1'b1);
        chk("after_glitch_irq", {7'd0, irq}, 8'h01);
        rd(ADDR_RXDATA, rdat);
        chk("after_glitch_data", rdat, 8'hA5);

        // Reset in the middle of a TX frame
        rd(ADDR_STATUS, rdat);
        wr(ADDR_TXDATA, 8'h00);
        repeat (DIV + 4) tick();
        chk("midtx_txd_low", {7'd0, txd}, 8'h00);
        arst = 1'b1;
        #1;
        chk("midtx_reset_txd", {7'd0, txd}, 8'h01);
        chk("midtx_reset_readdata", bus.avms_readdata_o, 8'h00);
        chk("midtx_reset_irq", {7'd0, irq}, 8'h00);
        tick();
        arst = 1'b0;
        tick();
        chk("post_reset_txd", {7'd0, txd}, 8'h01);
        rd(ADDR_RXDATA, rdat);
        chk("post_reset_rxdata", rdat, 8'h00);
        rd(ADDR_STATUS, rdat);
        chk("post_reset_status", rdat, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
